// File: rtl/serialadder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and width helpers used by the top level.
package serialadder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serialadder_fa.sv
// One-bit full adder used as the serial adder's datapath core.
module serialadder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serialadder.sv
// Bit-serial adder: loads two operands, adds one bit per enabled cycle LSB first,
// and publishes the full sum and carry only when all WIDTH bits are done.
module serialadder
    import serialadder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pload,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] bdata,
    input  logic             enable,
    output logic [WIDTH-1:0] pout,
    output logic             done,
    output logic             cout
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_shift;

    serialadder_fa u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
    assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        cout_d  = cout_q;
        done_d  = done_q;

        if (pload) begin
            a_d     = adata;
            b_d     = bdata;
            sum_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = ADD;
        end else begin
            unique case (state_q)
                ADD: begin
                    if (enable) begin
                        a_d     = a_q >> 1;
                        b_d     = b_q >> 1;
                        sum_d   = sum_shift;
                        carry_d = fa_co;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            pout_d  = sum_shift;
                            cout_d  = fa_co;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                IDLE, DONE: begin
                    // enable is ignored; everything holds until pload or reset.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            pout_q  <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign pout = pout_q;
    assign cout = cout_q;
    assign done = done_q;

endmodule

// File: tb/tb_serialadder.sv
// Self-checking bench for serialadder: directed vector table, pause/abort
// sequences and random operands, with a queue of expected results.
module tb_serialadder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pload = 1'b0;
    logic [W-1:0] adata = '0;
    logic [W-1:0] bdata = '0;
    logic         enable = 1'b0;
    logic [W-1:0] pout;
    logic         done;
    logic         cout;

    serialadder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .pload  (pload),
        .adata  (adata),
        .bdata  (bdata),
        .enable (enable),
        .pout   (pout),
        .done   (done),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
    } exp_t;

    vec_t         vecs[8];
    exp_t         sb[$];
    exp_t         e;
    logic [W-1:0] last_pout = '0;
    logic         last_cout = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs must show the previous result and done low while an addition is in flight.
    task automatic check_busy(input string name);
        check(name, {22'd0, done, cout, pout}, {22'd0, 1'b0, last_cout, last_pout});
    endtask

    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b};
        adata  = a;
        bdata  = b;
        pload  = 1'b1;
        enable = en;
        sb.push_back('{sum: full[W-1:0], co: full[W]});
        tick();
        pload  = 1'b0;
        enable = 1'b0;
        adata  = W'($urandom);
        bdata  = W'($urandom);
        check_busy("load_hold");
    endtask

    // Drive n enabled edges; last marks the segment whose final edge completes the sum.
    task automatic step_bits(input int n, input bit gaps, input bit last);
        int got = 0;
        int cyc = 0;
        bit en;
        while (got < n && cyc < 1000) begin
            en     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            enable = en;
            adata  = W'($urandom);
            bdata  = W'($urandom);
            tick();
            cyc++;
            if (en) got++;
            if (!(last && got == n)) check_busy("busy");
        end
        enable = 1'b0;
        if (got < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d enabled edges, required %0d", got, n);
        end
    endtask

    task automatic finish_op(input string name);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got empty scoreboard, required one entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_pout"}, {24'd0, pout}, {24'd0, e.sum});
            check({name, "_cout"}, {31'd0, cout}, {31'd0, e.co});
            check({name, "_done"}, {31'd0, done}, 32'd1);
            last_pout = e.sum;
            last_cout = e.co;
        end
    endtask

    initial begin
        vecs[0] = '{a: 8'h01, b: 8'h02, sum: 8'h03, co: 1'b0};
        vecs[1] = '{a: 8'h02, b: 8'h03, sum: 8'h05, co: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, co: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, co: 1'b1};
        vecs[4] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, co: 1'b0};
        vecs[5] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, co: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, co: 1'b1};
        vecs[7] = '{a: 8'h00, b: 8'h00, sum: 8'h00, co: 1'b0};

        // Reset
        #3 rst = 1'b0;
        #10;
        check("reset_pout", {24'd0, pout}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // IDLE ignores enable
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        check_busy("idle_enable");

        // Directed table; table sums checked against the scoreboard entries
        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].a, vecs[i].b, i[0]);
            step_bits(W, 1'b0, 1'b1);
            check("table_sum", {23'd0, cout, pout}, {23'd0, vecs[i].co, vecs[i].sum});
            finish_op("table");
        end

        // Pause after the 4th bit, then enable held long after done
        do_load(8'h0F, 8'h01, 1'b0);
        step_bits(4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_busy("pause_hold");
        end
        step_bits(4, 1'b0, 1'b1);
        check("pause_pout", {24'd0, pout}, 32'h10);
        finish_op("pause");
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adata = W'($urandom);
            tick();
        end
        enable = 1'b0;
        check("done_hold", {22'd0, done, cout, pout}, {22'd0, 1'b1, 1'b0, 8'h10});

        // Asynchronous reset after 5 bits aborts the addition
        do_load(8'h33, 8'h44, 1'b0);
        step_bits(5, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("abort_rst_out", {22'd0, done, cout, pout}, 32'd0);
        sb.delete();
        last_pout = '0;
        last_cout = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_busy("after_rst");
        end
        enable = 1'b0;

        // pload mid-addition restarts with new operands
        do_load(8'h33, 8'h44, 1'b0);
        step_bits(5, 1'b0, 1'b0);
        sb.delete();
        do_load(8'h10, 8'h20, 1'b1);
        step_bits(W, 1'b0, 1'b1);
        check("reload_pout", {24'd0, pout}, 32'h30);
        finish_op("reload");

        // Random pairs with random enable gaps
        for (int i = 0; i < 1000; i++) begin
            do_load(W'($urandom), W'($urandom), 1'($urandom));
            step_bits(W, 1'b1, 1'b1);
            finish_op("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serialadder.md
SERIALADDER -- requirements
Module: serialadder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits (>=2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 pload  input  1  parallel-load strobe for adata/bdata.
REQ-005 adata  input  WIDTH  operand A.
REQ-006 bdata  input  WIDTH  operand B.
REQ-007 enable  input  1  advance one serial bit per cycle while high.
REQ-008 pout  output  WIDTH  registered sum (A+B) mod 2^WIDTH.
REQ-009 done  output  1  registered; high while a completed result is held in pout.
REQ-010 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL have states IDLE, ADD and DONE.
REQ-012 pload=1 at a clock edge, in any state, SHALL:
- capture adata into shift register A and bdata into shift register B;
- clear the carry flop, the partial-sum register and the bit counter;
- clear done;
- enter ADD.
REQ-013 pload SHALL have priority over enable.
REQ-014 pout and cout SHALL hold their previous values on load.
REQ-015 In ADD with enable=1 and pload=0, each edge SHALL add A[0], B[0] and the carry with a 1-bit full adder.
REQ-016 On that edge the sum bit SHALL shift into the MSB of the partial-sum register (right shift), A and B SHALL shift right by one, the carry flop SHALL take the full-adder carry, and the counter SHALL increment.
REQ-017 In ADD with enable=0, all state SHALL hold (pause, no bit consumed).
REQ-018 On the WIDTH-th enabled edge after a load:
- pout SHALL take the complete WIDTH-bit sum;
- cout SHALL take the final carry;
- done SHALL go to 1;
- the state SHALL become DONE.
Latency is exactly WIDTH enabled cycles.
REQ-019 pout SHALL NOT show partial sums; it changes only on completion or reset.
REQ-020 In DONE, enable SHALL be ignored and pout, cout and done SHALL hold until the next pload or reset.
REQ-021 In IDLE, enable SHALL be ignored.
REQ-022 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported on cout (e.g. 0xFF+0x01 -> pout=0x00, cout=1).
REQ-023 adata and bdata SHALL be sampled only on pload edges; changes at other times SHALL have no effect.

Reset
REQ-024 rst=0 SHALL asynchronously force:
- state IDLE;
- pout=0, cout=0, done=0;
- A, B, partial-sum register, carry flop and counter all 0.
REQ-025 Reset asserted mid-addition SHALL abort the addition; no result is produced until the next pload.
REQ-026 After rst deasserts, the block SHALL act on the first rising edge.

Structure
REQ-027 A shared package serialadder_pkg SHALL hold:
- the state enum (IDLE/ADD/DONE);
- the default WIDTH constant;
- the counter width constant, $clog2(WIDTH)+1.
REQ-028 The 1-bit full adder SHALL be a sub-module named serialadder_fa (inputs a, b, ci; outputs s, co), instantiated once.
REQ-029 The FSM, shift registers, counter and output registers SHALL be in serialadder.

Verification
REQ-030 Reset, then load and add: rst low 10 ns -> pout=0, done=0. Then pload with adata=0x01, bdata=0x02, then enable=1 for 8 cycles -> pout=0x03, cout=0, done=1 after the 8th edge.
REQ-031 Second load on the same block: pload with adata=0x02, bdata=0x03 -> pout stays 0x03 and done=0 during the addition. After 8 enabled cycles -> pout=0x05, done=1.
REQ-032 Overflow: 0xFF+0x01 -> pout=0x00, cout=1. Then 0x80+0x80 -> pout=0x00, cout=1. Then 0xAA+0x55 -> pout=0xFF, cout=0.
REQ-033 Pause: drop enable for 3 cycles after the 4th bit of 0x0F+0x01 -> completes on the 8th enabled edge with pout=0x10. Holding enable high long after done -> pout unchanged.
REQ-034 Abort: assert rst low mid-addition (after 5 bits) -> outputs 0 immediately. Assert pload mid-addition with new operands 0x10+0x20 -> pout=0x30 after 8 more enabled cycles.
REQ-035 Random: 1000 random operand pairs with random enable gaps -> pout == (a+b) mod 256 and cout == carry-out for every pair.
